dreg_bank: RTL and testbench



---
 rtl/dreg_bank.sv | 94 +++++++++
 tb/tb_dreg_bank.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/dreg_bank.sv
// Bank of CHANNELS independent WIDTH-bit D registers, each loaded through a debounced enable.
// Optional macro DREG_BANK_CHANGE_EN builds a per-channel "value changed" strobe; otherwise change is 0.
module dreg_bank #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = 0,
    parameter int FILTER   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS-1:0]          En,
    input  logic [CHANNELS*WIDTH-1:0]    D,
    output logic [CHANNELS*WIDTH-1:0]    Q,
    output logic [CHANNELS*WIDTH-1:0]    not_Q,
    output logic [CHANNELS-1:0]          loaded,
    output logic [CHANNELS-1:0]          change
);

    localparam int CW = (FILTER < 1) ? 1 : $clog2(FILTER + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILTER);

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic             en_q_reg;
            logic             en_q_next;
            logic             en_q_d_reg;
            logic [CW-1:0]    cnt_reg;
            logic [CW-1:0]    cnt_next;
            logic [WIDTH-1:0] q_reg;
            logic [WIDTH-1:0] d_ch;
            logic             loaded_reg;
            logic             load;

            assign d_ch = D[gi*WIDTH +: WIDTH];

            // A raw enable change is accepted only after FILTER+1 consecutive samples
            always_comb begin
                en_q_next = en_q_reg;
                cnt_next  = '0;
                if (En[gi] != en_q_reg) begin
                    if (cnt_reg == CNT_MAX) begin
                        en_q_next = En[gi];
                        cnt_next  = '0;
                    end else begin
                        cnt_next = cnt_reg + CW'(1);
                    end
                end
            end

            // Edge mode loads only on the first cycle the qualified enable is seen high
            assign load = en_q_reg & ((MODE == 0) | ~en_q_d_reg);

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    en_q_reg   <= 1'b0;
                    en_q_d_reg <= 1'b0;
                    cnt_reg    <= '0;
                    q_reg      <= '0;
                    loaded_reg <= 1'b0;
                end else begin
                    en_q_reg   <= en_q_next;
                    en_q_d_reg <= en_q_reg;
                    cnt_reg    <= cnt_next;
                    if (load) begin
                        q_reg      <= d_ch;
                        loaded_reg <= 1'b1;
                    end
                end
            end

`ifdef DREG_BANK_CHANGE_EN
            logic change_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    change_reg <= 1'b0;
                end else begin
                    change_reg <= load && (d_ch != q_reg);
                end
            end

            assign change[gi] = change_reg;
`else
            assign change[gi] = 1'b0;
`endif

            assign Q[gi*WIDTH +: WIDTH]     = q_reg;
            assign not_Q[gi*WIDTH +: WIDTH] = ~q_reg;
            assign loaded[gi]               = loaded_reg;
        end
    endgenerate

endmodule

// File: tb/tb_dreg_bank.sv
// Directed bench for dreg_bank: a level-mode and an edge-mode instance, WIDTH=8, CHANNELS=2, FILTER=2.
module tb_dreg_bank;

    logic        clk;
    logic        rst_n;
    logic [1:0]  en0, en1;
    logic [15:0] d0, d1;
    logic [15:0] q0, nq0, q1, nq1;
    logic [1:0]  ld0, ld1, ch0, ch1;

    int n_checks;
    int n_fail;
    int pulses;
    int exp_pulses;

    dreg_bank #(.WIDTH(8), .CHANNELS(2), .MODE(0), .FILTER(2)) dut0 (
        .clk(clk), .rst_n(rst_n), .En(en0), .D(d0),
        .Q(q0), .not_Q(nq0), .loaded(ld0), .change(ch0)
    );

    dreg_bank #(.WIDTH(8), .CHANNELS(2), .MODE(1), .FILTER(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .En(en1), .D(d1),
        .Q(q1), .not_Q(nq1), .loaded(ld1), .change(ch1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef DREG_BANK_CHANGE_EN
        exp_pulses = 1;
`else
        exp_pulses = 0;
`endif
        // Reset with random inputs, checked before the first clock edge
        rst_n = 1'b0;
        en0 = 2'($urandom);
        en1 = 2'($urandom);
        d0  = 16'($urandom);
        d1  = 16'($urandom);
        #3;
        check("rst_q",      32'(q0),  32'h0000);
        check("rst_nq",     32'(nq0), 32'hFFFF);
        check("rst_loaded", 32'(ld0), 32'h0);
        check("rst_change", 32'(ch0), 32'h0);
        tick(2);
        check("rst_hold_q", 32'(q0),  32'h0000);
        check("rst_hold_q1",32'(q1),  32'h0000);
        check("rst_hold_ld",32'(ld1), 32'h0);
        en0 = 2'b00; en1 = 2'b00; d0 = 16'h0000; d1 = 16'h0000;
        rst_n = 1'b1;
        tick(1);

        // Level mode: first load FILTER+1 edges after enable rises
        d0[7:0] = 8'hA5; en0[0] = 1'b1;
        tick(3);
        check("m0_preload", 32'(q0), 32'h0000);
        tick(1);
        check("m0_first",   32'(q0), 32'h00A5);
        check("m0_loaded",  32'(ld0), 32'h1);
        d0[7:0] = 8'h3C;
        tick(1);
        check("m0_follow",  32'(q0),  32'h003C);
        check("m0_notq",    32'(nq0), 32'hFFC3);
        check("m0_loaded2", 32'(ld0), 32'h1);

        // Change strobe: four loads of the same new value, one pulse at most
        d0[7:0] = 8'h77;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            pulses += int'(ch0[0]);
        end
        check("chg_pulses", 32'(pulses), 32'(exp_pulses));
        check("chg_q",      32'(q0), 32'h0077);

        // Enable falls: loads continue through edge m+FILTER, then hold
        en0[0] = 1'b0; d0[7:0] = 8'h99;
        tick(3);
        check("m0_tail",    32'(q0), 32'h0099);
        d0[7:0] = 8'h44;
        tick(2);
        check("m0_hold",    32'(q0), 32'h0099);

        // Glitch on channel 1: two sampled edges rejected, three accepted
        en0[1] = 1'b1; d0[15:8] = 8'hBE;
        tick(2);
        en0[1] = 1'b0;
        tick(4);
        check("glitch_q",   32'(q0),  32'h0099);
        check("glitch_ld",  32'(ld0), 32'h1);
        en0[1] = 1'b1;
        tick(3);
        en0[1] = 1'b0;
        tick(4);
        check("pulse3_q",   32'(q0),  32'hBE99);
        check("pulse3_ld",  32'(ld0), 32'h3);

        // Edge mode: one load per assertion
        d1[7:0] = 8'h11; en1[0] = 1'b1;
        tick(4);
        check("m1_first",   32'(q1),  32'h0011);
        d1[7:0] = 8'h22;
        tick(3);
        check("m1_ignore",  32'(q1),  32'h0011);
        en1[0] = 1'b0;
        tick(3);
        en1[0] = 1'b1;
        tick(3);
        check("m1_prearm",  32'(q1),  32'h0011);
        tick(1);
        check("m1_second",  32'(q1),  32'h0022);
        check("m1_loaded",  32'(ld1), 32'h1);

        // Asynchronous reset while channel 0 is OPEN
        d0[7:0] = 8'h5A; en0[0] = 1'b1;
        tick(4);
        check("ar_open_q",  32'(q0[7:0]), 32'h5A);
        #2 rst_n = 1'b0;
        #1;
        check("ar_q",       32'(q0),  32'h0000);
        check("ar_nq",      32'(nq0), 32'hFFFF);
        check("ar_ld",      32'(ld0), 32'h0);
        #1 rst_n = 1'b1;
        tick(3);
        check("ar_relock",  32'(q0),  32'h0000);
        tick(1);
        check("ar_reload",  32'(q0),  32'h005A);
        check("ar_nq2",     32'(nq0), 32'hFFA5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
